// File: rtl/ushift_pkg.sv
// ---------------------------------------------------------------------------
// ushift_pkg
// Shared types for the universal burst shift register slice.
//   ushift_op_t    : 3-bit operation code (HOLD .. CLR)
//   ushift_state_t : burst sequencer state (IDLE, BURST)
//   isSingleOp     : ops that make no sense to repeat, so a burst of them
//                    collapses to a single step
// ---------------------------------------------------------------------------
package ushift_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_SHL  = 3'd1,
      OP_SHR  = 3'd2,
      OP_ROL  = 3'd3,
      OP_ROR  = 3'd4,
      OP_ASR  = 3'd5,
      OP_LOAD = 3'd6,
      OP_CLR  = 3'd7
   } ushift_op_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } ushift_state_t;

   // Repeating HOLD, LOAD or CLR gives the same result as doing it once,
   // so a burst of one of these is shortened to a single step.
   function automatic logic isSingleOp(ushift_op_t op);
      return (op == OP_HOLD) || (op == OP_LOAD) || (op == OP_CLR);
   endfunction

endpackage

// File: rtl/ushift_burst_reg_if.sv
// ---------------------------------------------------------------------------
// ushift_burst_reg_if
// Bundles the control, data and status signals of ushift_burst_reg.
//   en, op, sin_l, sin_r, pdata, start, cnt : driven by the master
//   out, sout_l, sout_r, busy, done         : driven by the slave (the register)
//   parity                                  : only when USHIFT_PARITY_EN is defined
// Modports: master (user of the register), slave (the register itself).
// ---------------------------------------------------------------------------
interface ushift_burst_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);

   logic             en;
   logic [2:0]       op;
   logic             sin_l;
   logic             sin_r;
   logic [WIDTH-1:0] pdata;
   logic             start;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] out;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;
`ifdef USHIFT_PARITY_EN
   logic             parity;
`endif

`ifdef USHIFT_PARITY_EN
   modport master (
      output en, op, sin_l, sin_r, pdata, start, cnt,
      input  out, sout_l, sout_r, busy, done, parity
   );

   modport slave (
      input  en, op, sin_l, sin_r, pdata, start, cnt,
      output out, sout_l, sout_r, busy, done, parity
   );
`else
   modport master (
      output en, op, sin_l, sin_r, pdata, start, cnt,
      input  out, sout_l, sout_r, busy, done
   );

   modport slave (
      input  en, op, sin_l, sin_r, pdata, start, cnt,
      output out, sout_l, sout_r, busy, done
   );
`endif

endinterface

// File: rtl/ushift_step.sv
// ---------------------------------------------------------------------------
// ushift_step
// Purely combinational next-value function of the shift register.
// Ports:
//   cur   in  WIDTH  current register contents
//   op    in  3      operation to apply (ushift_op_t)
//   sin_l in  1      serial bit shifted in at the MSB end (SHR)
//   sin_r in  1      serial bit shifted in at the LSB end (SHL)
//   pdata in  WIDTH  parallel load value (LOAD)
//   nxt   out WIDTH  value the register takes if this op is applied
// ---------------------------------------------------------------------------
module ushift_step
   import ushift_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  ushift_op_t       op,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] nxt
);

   // One case arm per operation; anything unexpected simply holds.
   always_comb begin
      nxt = cur;
      case (op)
         OP_HOLD: nxt = cur;
         OP_SHL:  nxt = {cur[WIDTH-2:0], sin_r};
         OP_SHR:  nxt = {sin_l, cur[WIDTH-1:1]};
         OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         OP_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
         OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
         OP_LOAD: nxt = pdata;
         OP_CLR:  nxt = '0;
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/ushift_burst_reg.sv
// ---------------------------------------------------------------------------
// ushift_burst_reg
// Universal shift register with a multi-cycle burst mode: one start request
// repeats a shift op cnt times while busy is high, then pulses done.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous active-high reset
//   bus  slave modport of ushift_burst_reg_if:
//        en, op, sin_l, sin_r, pdata, start, cnt  (inputs)
//        out, sout_l, sout_r, busy, done          (outputs)
//        parity (output, only with USHIFT_PARITY_EN defined): registered
//        XOR reduction of the value loaded into out on the same edge
// Optional feature macro: USHIFT_PARITY_EN
// ---------------------------------------------------------------------------
module ushift_burst_reg
   import ushift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input logic                clk,
   input logic                rst,
   ushift_burst_reg_if.slave  bus
);

   ushift_state_t    state, stateNext;
   logic [WIDTH-1:0] regOut, outNext;
   ushift_op_t       opLat, opLatNext;
   logic [WIDTH-1:0] pdataLat, pdataLatNext;
   logic [CNT_W-1:0] left, leftNext;
   logic             doneReg, doneNext;
   ushift_op_t       stepOp;
   logic [WIDTH-1:0] stepPdata;
   logic [WIDTH-1:0] stepVal;

   // In IDLE the live op/pdata drive the datapath (single-step mode);
   // during a burst the values captured with start are used instead,
   // while the serial inputs always stay live.
   always_comb begin
      stepOp    = ushift_op_t'(bus.op);
      stepPdata = bus.pdata;
      if (state == ST_BURST) begin
         stepOp    = opLat;
         stepPdata = pdataLat;
      end
   end

   ushift_step #(.WIDTH(WIDTH)) u_step (
      .cur   (regOut),
      .op    (stepOp),
      .sin_l (bus.sin_l),
      .sin_r (bus.sin_r),
      .pdata (stepPdata),
      .nxt   (stepVal)
   );

   // Next-state logic. With en low every register keeps its value, which
   // also freezes a pending done pulse. A start edge only captures op/cnt;
   // the first shift of a burst happens on the following enabled edge.
   always_comb begin
      stateNext    = state;
      outNext      = regOut;
      opLatNext    = opLat;
      pdataLatNext = pdataLat;
      leftNext     = left;
      doneNext     = doneReg;
      if (bus.en) begin
         case (state)
            ST_IDLE: begin
               doneNext = 1'b0;
               if (bus.start) begin
                  if (bus.cnt == '0) begin
                     doneNext = 1'b1;
                  end else begin
                     opLatNext    = ushift_op_t'(bus.op);
                     pdataLatNext = bus.pdata;
                     leftNext     = isSingleOp(ushift_op_t'(bus.op)) ? CNT_W'(1) : bus.cnt;
                     stateNext    = ST_BURST;
                  end
               end else begin
                  outNext = stepVal;
               end
            end
            ST_BURST: begin
               outNext  = stepVal;
               leftNext = left - CNT_W'(1);
               if (left == CNT_W'(1)) begin
                  stateNext = ST_IDLE;
                  doneNext  = 1'b1;
               end
            end
            default: stateNext = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers; reset wins over everything, including
   // an in-flight burst, and leaves no done pulse behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         regOut   <= '0;
         opLat    <= OP_HOLD;
         pdataLat <= '0;
         left     <= '0;
         doneReg  <= 1'b0;
      end else begin
         state    <= stateNext;
         regOut   <= outNext;
         opLat    <= opLatNext;
         pdataLat <= pdataLatNext;
         left     <= leftNext;
         doneReg  <= doneNext;
      end
   end

`ifdef USHIFT_PARITY_EN
   logic parityReg;

   // Parity tracks the value being written into out, so it is valid in the
   // same cycle as the new contents rather than one cycle behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         parityReg <= 1'b0;
      end else begin
         parityReg <= ^outNext;
      end
   end

   assign bus.parity = parityReg;
`endif

   assign bus.out    = regOut;
   assign bus.sout_l = regOut[WIDTH-1];
   assign bus.sout_r = regOut[0];
   assign bus.busy   = (state == ST_BURST);
   assign bus.done   = doneReg;

endmodule

// File: tb/tb_ushift_burst_reg.sv
// ---------------------------------------------------------------------------
// tb_ushift_burst_reg
// Directed testbench for ushift_burst_reg (WIDTH=8, CNT_W=4) with a
// behavioural reference model compared every cycle plus hand-computed
// literal expectations. Honours USHIFT_PARITY_EN when defined.
// ---------------------------------------------------------------------------
module tb_ushift_burst_reg;

   localparam int W  = 8;
   localparam int CW = 4;

   localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, ROL = 3'd3,
                          ROR  = 3'd4, ASR = 3'd5, LOAD = 3'd6, CLR = 3'd7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   compareOn = 1'b0;

   ushift_burst_reg_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   ushift_burst_reg #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Reference model state, expressed as plain arithmetic on integers.
   logic [W-1:0] mOut   = '0;
   logic         mBusy  = 1'b0;
   logic         mDone  = 1'b0;
   logic         mPar   = 1'b0;
   int           mLeft  = 0;
   int           mOp    = 0;
   logic [W-1:0] mPdata = '0;

   function automatic logic [W-1:0] modelOp(logic [W-1:0] v, int o, logic sl,
                                            logic sr, logic [W-1:0] pd);
      int vi;
      vi = int'(v);
      case (o)
         1: return W'(vi * 2 + int'(sr));
         2: return W'(vi / 2 + (sl ? 128 : 0));
         3: return W'(vi * 2 + vi / 128);
         4: return W'(vi / 2 + (vi % 2) * 128);
         5: return W'(vi / 2 + (vi >= 128 ? 128 : 0));
         6: return pd;
         7: return '0;
         default: return v;
      endcase
   endfunction

   // The model reacts to each rising edge exactly as the behaviour rules
   // describe: single steps in idle, a counted sequence of shifts in a burst.
   always @(posedge clk) begin
      if (rst) begin
         mOut  = '0;
         mBusy = 1'b0;
         mDone = 1'b0;
         mLeft = 0;
         mOp   = 0;
         mPar  = 1'b0;
      end else if (bus.en) begin
         if (!mBusy) begin
            mDone = 1'b0;
            if (bus.start) begin
               if (bus.cnt == 0) begin
                  mDone = 1'b1;
               end else begin
                  mOp    = int'(bus.op);
                  mPdata = bus.pdata;
                  mLeft  = (mOp == 0 || mOp == 6 || mOp == 7) ? 1 : int'(bus.cnt);
                  mBusy  = 1'b1;
               end
            end else begin
               mOut = modelOp(mOut, int'(bus.op), bus.sin_l, bus.sin_r, bus.pdata);
            end
         end else begin
            mOut  = modelOp(mOut, mOp, bus.sin_l, bus.sin_r, mPdata);
            mLeft = mLeft - 1;
            if (mLeft == 0) begin
               mBusy = 1'b0;
               mDone = 1'b1;
            end
         end
         mPar = ^mOut;
      end
   end

   task automatic compareOne(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Every falling edge the DUT outputs are compared with the model.
   always @(negedge clk) begin
      if (compareOn) begin
         compareOne("model_out",    int'(bus.out),    int'(mOut));
         compareOne("model_sout_l", int'(bus.sout_l), int'(mOut[W-1]));
         compareOne("model_sout_r", int'(bus.sout_r), int'(mOut[0]));
         compareOne("model_busy",   int'(bus.busy),   int'(mBusy));
         compareOne("model_done",   int'(bus.done),   int'(mDone));
`ifdef USHIFT_PARITY_EN
         compareOne("model_parity", int'(bus.parity), int'(mPar));
`endif
      end
   end

   // Drives one cycle of inputs and waits until just after the edge.
   task automatic applyStimulus(logic e, logic [2:0] o, logic sl, logic sr,
                                logic [W-1:0] pd, logic st, logic [CW-1:0] c);
      bus.en    = e;
      bus.op    = o;
      bus.sin_l = sl;
      bus.sin_r = sr;
      bus.pdata = pd;
      bus.start = st;
      bus.cnt   = c;
      @(posedge clk);
      #1;
   endtask

   // Hand-computed expectations that pin both the DUT and the model.
   task automatic checkOutput(string name, logic [W-1:0] expOut, logic expBusy, logic expDone);
      compareOne({name, "_out"},    int'(bus.out),    int'(expOut));
      compareOne({name, "_sout_l"}, int'(bus.sout_l), int'(expOut[W-1]));
      compareOne({name, "_sout_r"}, int'(bus.sout_r), int'(expOut[0]));
      compareOne({name, "_busy"},   int'(bus.busy),   int'(expBusy));
      compareOne({name, "_done"},   int'(bus.done),   int'(expDone));
   endtask

   // Directed scenario sequence.
   initial begin
      bus.en = 1'b0; bus.op = HOLD; bus.sin_l = 1'b0; bus.sin_r = 1'b0;
      bus.pdata = '0; bus.start = 1'b0; bus.cnt = '0;

      rst = 1'b1;
      applyStimulus(1, LOAD, 0, 0, 8'hFF, 0, 0);
      applyStimulus(1, LOAD, 0, 0, 8'hFF, 1, 5);
      compareOn = 1'b1;
      checkOutput("reset", 8'h00, 0, 0);
      rst = 1'b0;

      applyStimulus(1, LOAD, 0, 0, 8'hA5, 0, 0);
      checkOutput("load_a5", 8'hA5, 0, 0);
      applyStimulus(1, SHL, 1, 0, 8'h00, 0, 0);
      checkOutput("shl1", 8'h4A, 0, 0);
      applyStimulus(1, SHL, 1, 0, 8'h00, 0, 0);
      checkOutput("shl2", 8'h94, 0, 0);
      applyStimulus(1, SHL, 1, 0, 8'h00, 0, 0);
      checkOutput("shl3", 8'h28, 0, 0);
      applyStimulus(1, SHR, 1, 0, 8'h00, 0, 0);
      checkOutput("shr1", 8'h94, 0, 0);

      applyStimulus(1, LOAD, 0, 0, 8'h81, 0, 0);
      applyStimulus(1, ROL, 0, 0, 8'h00, 1, 4);
      checkOutput("rol_start", 8'h81, 1, 0);
      applyStimulus(1, LOAD, 0, 0, 8'h55, 1, 2);
      checkOutput("rol_s1", 8'h03, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("rol_s2", 8'h06, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("rol_s3", 8'h0C, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("rol_s4", 8'h18, 0, 1);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("rol_after", 8'h18, 0, 0);

      applyStimulus(1, LOAD, 0, 0, 8'h80, 0, 0);
      applyStimulus(1, ASR, 0, 0, 8'h00, 1, 3);
      checkOutput("asr_start", 8'h80, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("asr_s1", 8'hC0, 1, 0);
      applyStimulus(0, CLR, 0, 0, 8'h00, 1, 1);
      checkOutput("asr_frz1", 8'hC0, 1, 0);
      applyStimulus(0, CLR, 0, 0, 8'h00, 0, 0);
      checkOutput("asr_frz2", 8'hC0, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("asr_s2", 8'hE0, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("asr_s3", 8'hF0, 0, 1);
      applyStimulus(0, CLR, 0, 0, 8'h00, 0, 0);
      checkOutput("done_frozen", 8'hF0, 0, 1);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("done_clear", 8'hF0, 0, 0);

      applyStimulus(1, SHL, 0, 1, 8'h00, 1, 0);
      checkOutput("cnt0", 8'hF0, 0, 1);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("cnt0_after", 8'hF0, 0, 0);

      applyStimulus(1, ROR, 0, 0, 8'h00, 1, 9);
      checkOutput("ror_start", 8'hF0, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("ror_s1", 8'h78, 1, 0);
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("ror_s2", 8'h3C, 1, 0);
      rst = 1'b1;
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("abort_rst", 8'h00, 0, 0);
      rst = 1'b0;
      applyStimulus(1, HOLD, 0, 0, 8'h00, 0, 0);
      checkOutput("abort_after", 8'h00, 0, 0);

      // A burst whose done edge is immediately followed by a new start,
      // and a live sin_r feeding an SHL burst.
      applyStimulus(1, LOAD, 0, 0, 8'h3C, 0, 0);
      applyStimulus(1, SHL, 0, 0, 8'h00, 1, 2);
      applyStimulus(1, HOLD, 0, 1, 8'h00, 0, 0);
      applyStimulus(1, HOLD, 0, 1, 8'h00, 0, 0);
      checkOutput("shl_burst", 8'hF3, 0, 1);
      applyStimulus(1, SHR, 0, 0, 8'h00, 1, 1);
      checkOutput("restart", 8'hF3, 1, 0);
      applyStimulus(1, HOLD, 1, 0, 8'h00, 0, 0);
      checkOutput("restart_s1", 8'hF9, 0, 1);

`ifdef USHIFT_PARITY_EN
      applyStimulus(1, LOAD, 0, 0, 8'h07, 0, 0);
      compareOne("par_load", int'(bus.parity), 1);
      applyStimulus(1, ROL, 0, 0, 8'h00, 0, 0);
      compareOne("par_rol", int'(bus.parity), 1);
      applyStimulus(1, CLR, 0, 0, 8'h00, 0, 0);
      compareOne("par_clr", int'(bus.parity), 0);
`endif

      // Single-step sweep through every op with varied serial/load data;
      // the model comparison covers each cycle.
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1, 3'(i % 8), 1'(i / 3), 1'(i / 5), 8'(i * 37 + 11), 0, 0);
      end
      applyStimulus(1, LOAD, 0, 0, 8'hC3, 0, 0);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1, 3'(i), 1'(i), 1'(i + 1), 8'h5A, 1, 4'(i + 1));
         for (int k = 0; k < 10; k++) begin
            applyStimulus(1, HOLD, 1'(k), 1'(k / 2), 8'h00, 0, 0);
         end
      end

      compareOn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ushift_burst_reg.md
Name: ushift_burst_reg

Overview:
- Parametrised successor to the team's bidirectional shift register.
- Universal shift register: hold, logical shift left/right, rotate left/right, arithmetic shift right, parallel load, clear.
- Adds a multi-cycle burst mode: one start request applies a shift op N times, with busy/done handshake.
- Used as a datapath utility for serialisers, barrel-shift emulation and the LFSR/CRC blocks.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the burst count; max burst = 2**CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; when 0, register, FSM and counter hold.
- op  input  3  0 HOLD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6 LOAD, 7 CLR.
- sin_l  input  1  serial in at MSB end (used by SHR).
- sin_r  input  1  serial in at LSB end (used by SHL).
- pdata  input  WIDTH  parallel load data.
- start  input  1  burst request, sampled in IDLE with en=1.
- cnt  input  CNT_W  burst repeat count, sampled with start.
- out  output  WIDTH  register contents.
- sout_l  output  1  out[WIDTH-1], combinational from register.
- sout_r  output  1  out[0], combinational from register.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse after the last burst step.

Behaviour:
- Reset (rst=1 at a clk edge, overrides en): out=0, busy=0, done=0, FSM=IDLE, internal count=0, latched op=HOLD.
- Op semantics, applied once per enabled edge:
  - SHL: {out[W-2:0],sin_r}
  - SHR: {sin_l,out[W-1:1]}
  - ROL: {out[W-2:0],out[W-1]}
  - ROR: {out[0],out[W-1:1]}
  - ASR: {out[W-1],out[W-1:1]}
  - LOAD: pdata
  - CLR: 0
  - HOLD: out
- IDLE, en=1, start=0: op applied at that edge (single-step mode). Latency 1 cycle.
- IDLE, en=1, start=1: op and cnt latched at that edge. No data change on this edge.
  - cnt=0: stay IDLE; done=1 next cycle.
  - op in {HOLD, LOAD, CLR}: treated as one step regardless of cnt.
  - otherwise: FSM->BURST, busy=1 from next cycle, remaining count = cnt.
- BURST, en=1: latched op applied each edge and remaining count decremented.
  - The edge that takes the count 1->0 returns FSM to IDLE, drops busy and sets done=1 for exactly one cycle.
  - Total shifts = cnt; done is visible in the cycle after the last shift.
- BURST: op, start, cnt and pdata are ignored. Serial inputs sin_l/sin_r are still sampled live each step.
- en=0 in any state: everything frozen, including a pending done pulse. done stays high until the next enabled edge clears it.
- start while busy: ignored, no queuing.
- rst mid-burst: abort immediately to reset values; no done pulse.
- done is cleared on the next enabled edge; a new start may be accepted on that same edge.

Optional Feature:
- Macro USHIFT_PARITY_EN.
- Defined: extra output port parity (1 bit), registered, equal to the XOR reduction of the next-state value of out. Updated on the same edge as out; reset 0. Ports and behaviour are otherwise identical.
- Undefined: no parity port or logic.

Decomposition:
- Shared package ushift_pkg holds:
  - op enum typedef ushift_op_t (HOLD..CLR, 3 bits)
  - FSM state typedef (IDLE, BURST)
- Natural sub-module: ushift_step, a combinational next-value function of (out, op, sin_l, sin_r, pdata). The top level holds the FSM, counter and registers.

Test Plan (WIDTH=8, CNT_W=4):
- Reset then LOAD pdata=8'hA5 -> out=8'hA5 one cycle later; busy=0, done=0, sout_l=1, sout_r=1.
- From 8'hA5, single-step SHL with sin_r=0 for 3 cycles -> 8'h4A, 8'h94, 8'h28; then SHR with sin_l=1 -> 8'h94.
- From 8'h81, start ROL with cnt=4 -> busy high 4 cycles, out=8'h18, done pulses exactly 1 cycle; start asserted mid-burst is ignored.
- From 8'h80, ASR burst cnt=3 with en dropped for 2 cycles mid-burst -> out=8'hF0, busy extended by 2 cycles, done after the third shift.
- Burst cnt=0 -> out unchanged, busy never high, done=1 one cycle later. rst asserted during a cnt=9 burst -> out=0, busy=0, no done.
- With USHIFT_PARITY_EN: LOAD 8'h07 -> parity=1; ROL -> parity remains 1; CLR -> parity=0.
